tt_um_mbist: RTL and testbench

- Self-contained memory built-in self-test (MBIST) block in the TinyTapeout user-project wrapper.
- Contains a 16x8 register-file SRAM model and a March C- controller.
- Optional fault injection makes failures observable on silicon.
- Reports done/fail and the first failing address and data on the standard TT pins.

---
 rtl/mbist_pkg.sv | 43 ++++
 rtl/mbist_if.sv | 19 +
 rtl/mbist_sram.sv | 32 +++
 rtl/tt_um_mbist.sv | 167 ++++++++++++++++
 tb/tb_tt_um_mbist.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/mbist_pkg.sv
// ---------------------------------------------------------------------------
// mbist_pkg
//   Shared types and constants for the March C- memory BIST block:
//   controller state encoding, memory geometry, data patterns and the
//   per-element March C- tables (direction, read/write presence and values).
// ---------------------------------------------------------------------------
package mbist_pkg;

   localparam int DEPTH    = 16;
   localparam int WIDTH    = 8;
   localparam int AW       = $clog2(DEPTH);
   localparam int NUM_ELEM = 6;
   localparam int EW       = 3;

   localparam logic [WIDTH-1:0] DATA0 = 8'h00;
   localparam logic [WIDTH-1:0] DATA1 = 8'hFF;

   localparam logic [AW-1:0] ADDR_LO = '0;
   localparam logic [AW-1:0] ADDR_HI = AW'(DEPTH - 1);
   localparam logic [EW-1:0] LAST_ELEM = EW'(NUM_ELEM - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   // Element tables, bit e describes element Me. Padded to 2**EW bits so the
   // 3-bit element counter always indexes inside the vector.
   //   M0 up(w0)  M1 up(r0,w1)  M2 up(r1,w0)
   //   M3 dn(r0,w1)  M4 dn(r1,w0)  M5 up(r0)
   localparam logic [7:0] ELEM_DOWN   = 8'b0001_1000;
   localparam logic [7:0] ELEM_HAS_RD = 8'b0011_1110;
   localparam logic [7:0] ELEM_HAS_WR = 8'b0001_1111;
   localparam logic [7:0] ELEM_RD_ONE = 8'b0001_0100;
   localparam logic [7:0] ELEM_WR_ONE = 8'b0000_1010;

   // First address visited by an element.
   function automatic logic [AW-1:0] first_addr(input logic [EW-1:0] e);
      return ELEM_DOWN[e] ? ADDR_HI : ADDR_LO;
   endfunction

endpackage

// File: rtl/mbist_if.sv
// ---------------------------------------------------------------------------
// mbist_if
//   Memory access bus between the BIST controller and the SRAM model.
//   we/addr/wdata flow controller -> memory; rdata is the combinational
//   read of word addr.
//   Modports: master (controller), slave (memory).
// ---------------------------------------------------------------------------
interface mbist_if;
   import mbist_pkg::*;

   logic             we;
   logic [AW-1:0]    addr;
   logic [WIDTH-1:0] wdata;
   logic [WIDTH-1:0] rdata;

   modport master (output we, output addr, output wdata, input rdata);
   modport slave  (input we, input addr, input wdata, output rdata);

endinterface

// File: rtl/mbist_sram.sv
// ---------------------------------------------------------------------------
// mbist_sram
//   DEPTH x WIDTH register file: synchronous write, asynchronous read.
//   Contents are never reset. When fault_en is high, bit 0 of word
//   fault_addr reads back as 0 (stuck-at-0 on the read path only).
//   Ports:
//     clk        - write clock
//     bus        - slave side of mbist_if
//     fault_en   - enable stuck-at-0 injection
//     fault_addr - word carrying the injected fault
// ---------------------------------------------------------------------------
module mbist_sram
   import mbist_pkg::*;
(
   input  logic          clk,
   mbist_if.slave        bus,
   input  logic          fault_en,
   input  logic [AW-1:0] fault_addr
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (bus.we) mem[bus.addr] <= bus.wdata;
   end

   always_comb begin
      bus.rdata = mem[bus.addr];
      if (fault_en && (bus.addr == fault_addr)) bus.rdata[0] = 1'b0;
   end

endmodule

// File: rtl/tt_um_mbist.sv
// ---------------------------------------------------------------------------
// tt_um_mbist
//   TinyTapeout wrapper around a March C- BIST controller and a 16x8 SRAM.
//   Ports:
//     clk     - system clock
//     rst_n   - synchronous reset, asserted HIGH (legacy TT pin name)
//     ena     - design select, unused
//     ui_in   - [0] start, [1] fault_en, [7:4] fault_addr
//     uo_out  - [0] done, [1] fail, [2] busy, [3] 0, [7:4] fail_addr
//     uio_in  - unused
//     uio_out - read data captured at the first failing compare
//     uio_oe  - all ones
//   One memory operation per RUN cycle; 160 operations total.
// ---------------------------------------------------------------------------
module tt_um_mbist
   import mbist_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   mbist_if bus ();

   mbist_sram u_sram (
      .clk        (clk),
      .bus        (bus),
      .fault_en   (ui_in[1]),
      .fault_addr (ui_in[7:4])
   );

   logic start;
   assign start = ui_in[0];

   logic unused_ok;
   assign unused_ok = &{1'b0, ena, uio_in, ui_in[3:2]};

   state_e           state_q,     state_d;
   logic [EW-1:0]    elem_q,      elem_d;
   logic [AW-1:0]    addr_q,      addr_d;
   logic             phase_q,     phase_d;
   logic             done_q,      done_d;
   logic             fail_q,      fail_d;
   logic             busy_q,      busy_d;
   logic [AW-1:0]    fail_addr_q, fail_addr_d;
   logic [WIDTH-1:0] fail_data_q, fail_data_d;

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q     <= S_IDLE;
         elem_q      <= '0;
         addr_q      <= '0;
         phase_q     <= 1'b0;
         done_q      <= 1'b0;
         fail_q      <= 1'b0;
         busy_q      <= 1'b0;
         fail_addr_q <= '0;
         fail_data_q <= '0;
      end else begin
         state_q     <= state_d;
         elem_q      <= elem_d;
         addr_q      <= addr_d;
         phase_q     <= phase_d;
         done_q      <= done_d;
         fail_q      <= fail_d;
         busy_q      <= busy_d;
         fail_addr_q <= fail_addr_d;
         fail_data_q <= fail_data_d;
      end
   end

   logic             is_read;
   logic             addr_last_op;
   logic             addr_at_end;
   logic [EW-1:0]    elem_nxt;
   logic [WIDTH-1:0] exp_data;

   always_comb begin
      state_d     = state_q;
      elem_d      = elem_q;
      addr_d      = addr_q;
      phase_d     = phase_q;
      done_d      = done_q;
      fail_d      = fail_q;
      busy_d      = busy_q;
      fail_addr_d = fail_addr_q;
      fail_data_d = fail_data_q;

      bus.we    = 1'b0;
      bus.addr  = addr_q;
      bus.wdata = DATA0;

      // Phase 0 is the read when the element has one, otherwise the write.
      is_read      = ELEM_HAS_RD[elem_q] && !phase_q;
      // An address is finished after phase 1, or after phase 0 when the
      // element only has a single operation.
      addr_last_op = phase_q || !(ELEM_HAS_RD[elem_q] && ELEM_HAS_WR[elem_q]);
      addr_at_end  = ELEM_DOWN[elem_q] ? (addr_q == ADDR_LO) : (addr_q == ADDR_HI);
      elem_nxt     = elem_q + EW'(1);
      exp_data     = ELEM_RD_ONE[elem_q] ? DATA1 : DATA0;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d     = S_RUN;
               elem_d      = '0;
               addr_d      = first_addr('0);
               phase_d     = 1'b0;
               done_d      = 1'b0;
               fail_d      = 1'b0;
               busy_d      = 1'b1;
               fail_addr_d = '0;
               fail_data_d = '0;
            end
         end

         S_RUN: begin
            if (is_read) begin
               if ((bus.rdata != exp_data) && !fail_q) begin
                  fail_d      = 1'b1;
                  fail_addr_d = addr_q;
                  fail_data_d = bus.rdata;
               end
            end else begin
               bus.we    = 1'b1;
               bus.wdata = ELEM_WR_ONE[elem_q] ? DATA1 : DATA0;
            end

            if (addr_last_op) begin
               phase_d = 1'b0;
               if (addr_at_end) begin
                  if (elem_q == LAST_ELEM) begin
                     state_d = S_DONE;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                  end else begin
                     elem_d = elem_nxt;
                     addr_d = first_addr(elem_nxt);
                  end
               end else begin
                  addr_d = ELEM_DOWN[elem_q] ? addr_q - AW'(1) : addr_q + AW'(1);
               end
            end else begin
               phase_d = 1'b1;
            end
         end

         S_DONE: begin
            busy_d = 1'b0;
            done_d = 1'b1;
            if (!start) state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign uo_out  = {fail_addr_q, 1'b0, busy_q, fail_q, done_q};
   assign uio_out = fail_data_q;
   assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_mbist.sv
module tb_tt_um_mbist;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uo_out;
   logic [7:0] uio_in;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int tests;
   int fails;

   tt_um_mbist dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uo_out  (uo_out),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   // Stand-alone memory on its own bus for direct fault-injection checks.
   mbist_if    sbus ();
   logic       s_fe;
   logic [3:0] s_fa;

   mbist_sram u_sram_chk (
      .clk        (clk),
      .bus        (sbus),
      .fault_en   (s_fe),
      .fault_addr (s_fa)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Behavioural March C-: walk the element list on an array, apply the
   // stuck-at-0 on reads, record the first mismatch and count operations.
   task automatic march_model(input bit fe, input int fa,
                              output bit f, output int faddr,
                              output logic [7:0] fdata, output int nops);
      // op codes: 0=w0 1=w1 2=r0 3=r1 -1=none
      int ops  [6][2] = '{'{0,-1}, '{2,1}, '{3,0}, '{2,1}, '{3,0}, '{2,-1}};
      bit down [6]    = '{0, 0, 0, 1, 1, 0};
      logic [7:0] m [16];
      logic [7:0] rd;
      f = 0; faddr = 0; fdata = 8'h00; nops = 0;
      for (int e = 0; e < 6; e++) begin
         for (int i = 0; i < 16; i++) begin
            int a;
            a = down[e] ? 15 - i : i;
            for (int k = 0; k < 2; k++) begin
               if (ops[e][k] < 0) continue;
               nops++;
               case (ops[e][k])
                  0: m[a] = 8'h00;
                  1: m[a] = 8'hFF;
                  default: begin
                     rd = m[a];
                     if (fe && a == fa) rd[0] = 1'b0;
                     if (rd != ((ops[e][k] == 3) ? 8'hFF : 8'h00) && !f) begin
                        f = 1; faddr = a; fdata = rd;
                     end
                  end
               endcase
            end
         end
      end
   endtask

   task automatic run_march(input bit fe, input int fa, input string tag);
      bit         ef;
      int         ea;
      logic [7:0] ed;
      int         nops;
      int         cycles;
      logic [7:0] exp_uo;
      march_model(fe, fa, ef, ea, ed, nops);
      exp_uo = {ea[3:0], 1'b0, 1'b0, ef, 1'b1};

      @(negedge clk);
      ui_in = {fa[3:0], 2'b00, fe, 1'b1};
      @(posedge clk);
      @(negedge clk);
      check({tag, "_start_uo"}, 32'(uo_out), 32'h04);
      check({tag, "_start_uio"}, 32'(uio_out), 32'h00);

      cycles = 0;
      while (cycles < 400) begin
         @(posedge clk);
         cycles++;
         @(negedge clk);
         if (uo_out[0]) break;
      end
      check({tag, "_cycles"}, 32'(cycles), 32'(nops));
      check({tag, "_uo"}, 32'(uo_out), 32'(exp_uo));
      check({tag, "_uio"}, 32'(uio_out), 32'(ed));

      // start held high in DONE must not restart
      repeat (2) @(posedge clk);
      @(negedge clk);
      check({tag, "_hold_uo"}, 32'(uo_out), 32'(exp_uo));

      // back to IDLE, results held
      ui_in[0] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check({tag, "_idle_uo"}, 32'(uo_out), 32'(exp_uo));
      check({tag, "_idle_uio"}, 32'(uio_out), 32'(ed));
   endtask

   initial begin
      logic [7:0] r;
      tests = 0;
      fails = 0;
      ena = 1'b1;
      uio_in = 8'h00;
      ui_in = 8'h00;
      rst_n = 1'b1;
      sbus.we = 1'b0;
      sbus.addr = '0;
      sbus.wdata = '0;
      s_fe = 1'b0;
      s_fa = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_uo", 32'(uo_out), 32'h00);
      check("reset_uio", 32'(uio_out), 32'h00);
      check("reset_oe", 32'(uio_oe), 32'hFF);
      rst_n = 1'b0;

      run_march(1'b0, 0, "clean");
      run_march(1'b1, 5, "fault5");
      run_march(1'b1, 15, "fault15");
      run_march(1'b0, 0, "restart");

      // Mid-run reset during a faulted run, after the capture has happened.
      @(negedge clk);
      ui_in = 8'h23;
      @(posedge clk);
      repeat (80) @(posedge clk);
      @(negedge clk);
      check("midrun_busy", 32'(uo_out[2]), 32'h1);
      rst_n = 1'b1;
      ui_in = 8'h00;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      check("midrun_rst_uo", 32'(uo_out), 32'h00);
      check("midrun_rst_uio", 32'(uio_out), 32'h00);
      @(posedge clk);
      @(negedge clk);
      check("midrun_idle_uo", 32'(uo_out), 32'h00);
      run_march(1'b0, 0, "after_rst");

      repeat (4) begin
         bit fe;
         int fa;
         fe = 1'($urandom_range(0, 1));
         fa = int'($urandom_range(0, 15));
         run_march(fe, fa, "rand");
      end

      // Direct memory checks: write/read and read-path stuck-at-0.
      r = 8'($urandom) | 8'h01;
      @(negedge clk);
      sbus.we = 1'b1;
      sbus.addr = 4'd3;
      sbus.wdata = r;
      @(posedge clk);
      @(negedge clk);
      sbus.we = 1'b0;
      #1 check("sram_rd", 32'(sbus.rdata), 32'(r));
      s_fe = 1'b1;
      s_fa = 4'd3;
      #1 check("sram_fault_hit", 32'(sbus.rdata), 32'(r & 8'hFE));
      s_fa = 4'd4;
      #1 check("sram_fault_miss", 32'(sbus.rdata), 32'(r));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
